game_sound: RTL
===============

Name: game_sound

Overview:
Sound-effect generator that consumes the single-cycle hit, wall and goal event pulses from the game controller and drives a 1-bit square-wave speaker output. Each event type plays a tone with its own pitch and duration. Sits beside the VGA renderer at the top level, on the same clock as the controller. Higher-priority events preempt lower ones.

Parameters:
CLK_HZ, 25000000, system clock frequency; ms tick period = CLK_HZ/1000 cycles
HIT_HALF, 25000, hit tone half-period in clocks (500 Hz at 25 MHz)
WALL_HALF, 50000, wall tone half-period in clocks (250 Hz)
GOAL_HALF, 12500, goal tone half-period in clocks (1 kHz)
HIT_MS, 40, hit tone duration in ms
WALL_MS, 20, wall tone duration in ms
GOAL_MS, 300, goal tone duration in ms (max 1023)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
hit  in  1  paddle-hit event pulse, 1 cycle
wall  in  1  wall-bounce event pulse, 1 cycle
goal  in  1  goal/point event pulse, 1 cycle
mute  in  1  level; 1 = speaker held low, timing unaffected
speaker  out  1  square-wave audio output
busy  out  1  1 while a tone is playing
sound_id  out  2  current tone: 00 none, 01 wall, 10 hit, 11 goal

Behaviour:
- Reset (async): state IDLE, speaker=0, busy=0, sound_id=00, all counters 0.
- Priority: goal(3) > hit(2) > wall(1). Same-cycle events: highest wins, others dropped.
- Accept rule: event accepted if IDLE, or if its priority >= priority of tone playing. Lower-priority event while busy is dropped (not queued).
- On accept at edge E: state PLAY, busy=1, sound_id set, speaker=0, phase counter, ms prescaler and duration counter all cleared. Retrigger of same priority restarts fully.
- Phase counter counts clocks; at count HALF-1 wraps to 0 and speaker toggles. First rising edge of speaker at edge E+HALF; toggles every HALF cycles thereafter.
- ms prescaler wraps at CLK_HZ/1000-1 producing ms_tick; duration counter increments on ms_tick. When duration reaches DUR_MS (edge E+DUR_MS*CLK_HZ/1000): state IDLE, busy=0, sound_id=00, speaker=0.
- Event accepted in the same cycle tone ends: new tone starts, busy stays 1, no IDLE cycle.
- mute=1: speaker output gated to 0 combinationally after the register; internal toggle and duration continue; busy/sound_id unaffected.
- Widths: phase counter $clog2(max HALF) bits, prescaler $clog2(CLK_HZ/1000) bits, duration 10 bits. No overflow possible within parameter limits.
- Reset asserted mid-tone: immediate return to reset values.

Optional Feature:
GOAL_JINGLE_EN: defined -> goal plays two notes: GOAL_MS/2 ms at GOAL_HALF then GOAL_MS-GOAL_MS/2 ms at GOAL_HALF/2 (octave up), via extra state PLAY2; at note change speaker=0 and phase counter cleared; sound_id stays 11 throughout; preemption rules unchanged (goal retrigger restarts from note 1). Undefined -> goal is a single GOAL_MS tone at GOAL_HALF, no PLAY2 state.

Test Plan:
(Bench params: CLK_HZ=10000 → 10 clocks/ms, HIT_HALF=3, WALL_HALF=5, GOAL_HALF=2, HIT_MS=4, WALL_MS=2, GOAL_MS=6.)
1. Reset then idle 100 cycles -> speaker=0, busy=0, sound_id=00 throughout.
2. hit pulse accepted edge E -> busy=1, id=10 from E; speaker rises E+3, falls E+6, period 6; busy=0, id=00, speaker=0 at E+40.
3. hit at E, wall at E+10 -> wall ignored, id stays 10, end at E+40; then goal at E+50, hit at E+60 -> hit ignored, goal ends E+110.
4. wall at E, goal at E+5 -> id=11 from E+5, speaker 0 at E+5, rises E+7, busy drops E+65; hit+wall+goal same cycle -> id=11.
5. hit with mute=1 for whole tone -> speaker=0 always, busy high 40 cycles; release mute at E+20 -> speaker resumes in phase (high on E+21..E+23).
6. GOAL_JINGLE_EN defined, goal at E -> half-period 2 for E..E+30, speaker=0 at E+30, half-period 1 until E+60, busy drops E+60; undefined -> half-period 2 until E+60.

Source files
------------

// File: rtl/game_sound.sv
// Square-wave sound-effect generator for hit/wall/goal events with priority preemption.
// Define GOAL_JINGLE_EN to play the goal tone as two notes, the second an octave up.
module game_sound #(
    parameter int unsigned CLK_HZ    = 25000000,
    parameter int unsigned HIT_HALF  = 25000,
    parameter int unsigned WALL_HALF = 50000,
    parameter int unsigned GOAL_HALF = 12500,
    parameter int unsigned HIT_MS    = 40,
    parameter int unsigned WALL_MS   = 20,
    parameter int unsigned GOAL_MS   = 300
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hit,
    input  logic       wall,
    input  logic       goal,
    input  logic       mute,
    output logic       speaker,
    output logic       busy,
    output logic [1:0] sound_id
);

    localparam int unsigned TICKS    = CLK_HZ / 1000;
    localparam int unsigned MAX_HALF =
        (HIT_HALF > WALL_HALF) ? ((HIT_HALF > GOAL_HALF) ? HIT_HALF : GOAL_HALF)
                               : ((WALL_HALF > GOAL_HALF) ? WALL_HALF : GOAL_HALF);
    localparam int unsigned PW = (MAX_HALF > 1) ? $clog2(MAX_HALF) : 1;
    localparam int unsigned TW = (TICKS > 1) ? $clog2(TICKS) : 1;

    localparam logic [PW-1:0] HIT_LIM  = PW'(HIT_HALF - 1);
    localparam logic [PW-1:0] WALL_LIM = PW'(WALL_HALF - 1);
    localparam logic [PW-1:0] GOAL_LIM = PW'(GOAL_HALF - 1);
    localparam logic [TW-1:0] TICK_LIM = TW'(TICKS - 1);
    localparam logic [9:0]    HIT_DUR  = 10'(HIT_MS);
    localparam logic [9:0]    WALL_DUR = 10'(WALL_MS);
    localparam logic [9:0]    GOAL_DUR = 10'(GOAL_MS);

`ifdef GOAL_JINGLE_EN
    localparam int unsigned   GOAL2_HALF = (GOAL_HALF > 1) ? GOAL_HALF / 2 : 1;
    localparam logic [PW-1:0] GOAL2_LIM  = PW'(GOAL2_HALF - 1);
    localparam logic [9:0]    GOAL1_DUR  = 10'(GOAL_MS / 2);
    typedef enum logic [1:0] {StIdle, StPlay, StPlay2} state_e;
`else
    typedef enum logic [0:0] {StIdle, StPlay} state_e;
`endif

    state_e        state_q, state_d;
    logic          spk_q, spk_d;
    logic          busy_q, busy_d;
    logic [1:0]    sound_id_q, sound_id_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [TW-1:0] pre_q, pre_d;
    logic [9:0]    dur_q, dur_d;

    logic [1:0]    ev_id;
    logic          accept;
    logic [PW-1:0] half_lim;
    logic [9:0]    dur_lim;
    logic [9:0]    dur_inc;
    logic          ms_tick;
    logic          wrap;

    always_comb begin
        if (goal)      ev_id = 2'd3;
        else if (hit)  ev_id = 2'd2;
        else if (wall) ev_id = 2'd1;
        else           ev_id = 2'd0;
        // sound_id_q is 00 when idle, so any event passes then
        accept = (ev_id != 2'd0) && (ev_id >= sound_id_q);
    end

    always_comb begin
        case (sound_id_q)
            2'd1:    begin half_lim = WALL_LIM; dur_lim = WALL_DUR; end
            2'd2:    begin half_lim = HIT_LIM;  dur_lim = HIT_DUR;  end
            default: begin half_lim = GOAL_LIM; dur_lim = GOAL_DUR; end
        endcase
`ifdef GOAL_JINGLE_EN
        if (state_q == StPlay2)                         half_lim = GOAL2_LIM;
        if (state_q == StPlay && sound_id_q == 2'd3)    dur_lim  = GOAL1_DUR;
`endif
    end

    assign ms_tick = (pre_q == TICK_LIM);
    assign wrap    = (phase_q == half_lim);
    assign dur_inc = dur_q + 10'd1;

    always_comb begin
        state_d    = state_q;
        spk_d      = spk_q;
        busy_d     = busy_q;
        sound_id_d = sound_id_q;
        phase_d    = phase_q;
        pre_d      = pre_q;
        dur_d      = dur_q;
        if (accept) begin
            state_d    = StPlay;
            spk_d      = 1'b0;
            busy_d     = 1'b1;
            sound_id_d = ev_id;
            phase_d    = '0;
            pre_d      = '0;
            dur_d      = '0;
        end else if (state_q != StIdle) begin
            phase_d = wrap ? '0 : phase_q + PW'(1);
            spk_d   = wrap ? ~spk_q : spk_q;
            pre_d   = ms_tick ? '0 : pre_q + TW'(1);
            if (ms_tick) dur_d = dur_inc;
            if (ms_tick && dur_inc == dur_lim) begin
`ifdef GOAL_JINGLE_EN
                if (state_q == StPlay && sound_id_q == 2'd3) begin
                    // duration keeps counting across the note change
                    state_d = StPlay2;
                    spk_d   = 1'b0;
                    phase_d = '0;
                end else begin
`endif
                    state_d    = StIdle;
                    spk_d      = 1'b0;
                    busy_d     = 1'b0;
                    sound_id_d = 2'd0;
                    phase_d    = '0;
                    pre_d      = '0;
                    dur_d      = '0;
`ifdef GOAL_JINGLE_EN
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            spk_q      <= 1'b0;
            busy_q     <= 1'b0;
            sound_id_q <= 2'd0;
            phase_q    <= '0;
            pre_q      <= '0;
            dur_q      <= '0;
        end else begin
            state_q    <= state_d;
            spk_q      <= spk_d;
            busy_q     <= busy_d;
            sound_id_q <= sound_id_d;
            phase_q    <= phase_d;
            pre_q      <= pre_d;
            dur_q      <= dur_d;
        end
    end

    assign speaker  = spk_q & ~mute;
    assign busy     = busy_q;
    assign sound_id = sound_id_q;

endmodule
